// File: rtl/sreg_ctrl_if.sv
// Request/response bundle between the flag controller, its requesters (ALU, I/O bus,
// interrupt context logic) and the status register it drives.
interface sreg_ctrl_if #(
   parameter int W     = 3,
   parameter int DEPTH = 4
);
   localparam int DW = $clog2(DEPTH + 1);

   logic          alu_req;
   logic [W-1:0]  alu_mask;
   logic [W-1:0]  alu_flags;
   logic          alu_stall;

   logic          bus_wr_req;
   logic          bus_rd_req;
   logic [W-1:0]  bus_wdata;
   logic          bus_ack;
   logic [W-1:0]  bus_rdata;

   logic          ctx_save;
   logic          ctx_restore;
   logic          ctx_err;
   logic [DW-1:0] ctx_depth;

   logic          sr_we;
   logic          sr_re;
   logic [W-1:0]  sr_wdata;
   logic [W-1:0]  sr_rdata;

   // Requesters and the status register model
   modport master (
      output alu_req, alu_mask, alu_flags,
      input  alu_stall,
      output bus_wr_req, bus_rd_req, bus_wdata,
      input  bus_ack, bus_rdata,
      output ctx_save, ctx_restore,
      input  ctx_err, ctx_depth,
      input  sr_we, sr_re, sr_wdata,
      output sr_rdata
   );

   // The flag controller
   modport slave (
      input  alu_req, alu_mask, alu_flags,
      output alu_stall,
      input  bus_wr_req, bus_rd_req, bus_wdata,
      output bus_ack, bus_rdata,
      input  ctx_save, ctx_restore,
      output ctx_err, ctx_depth,
      output sr_we, sr_re, sr_wdata,
      input  sr_rdata
   );
endinterface

// File: rtl/sreg_ctrl.sv
// Status-flag controller: owns the authoritative flag copy, arbitrates context-stack,
// bus and ALU updates, and refreshes the status register every cycle.
module sreg_ctrl #(
   parameter int W     = 3,
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   sreg_ctrl_if.slave io
);
   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, BUS_WR, BUS_RD} state_t;

   state_t        r_state, w_state_nxt;
   logic [W-1:0]  r_flags, w_flags_nxt, w_alu_merge;
   logic [W-1:0]  r_wlatch, r_rdata;
   logic [W-1:0]  r_stack [DEPTH];
   logic [DW-1:0] r_depth;
   logic          r_ack, r_err, r_run;

   logic          w_ctx, w_both, w_save, w_rest, w_full, w_empty;
   logic          w_push, w_pop, w_err_nxt;
   logic          w_latch, w_commit_wr, w_commit_rd, w_alu_go;
   logic [AW-1:0] w_push_idx, w_pop_idx;
   logic          w_unused_sr_rdata;

   // The register read-back is monitor only; r_flags is authoritative
   assign w_unused_sr_rdata = ^io.sr_rdata;

   assign w_ctx      = io.ctx_save | io.ctx_restore;
   assign w_both     = io.ctx_save & io.ctx_restore;
   assign w_save     = io.ctx_save & ~io.ctx_restore;
   assign w_rest     = io.ctx_restore & ~io.ctx_save;
   assign w_full     = (r_depth == DW'(DEPTH));
   assign w_empty    = (r_depth == '0);
   assign w_push     = w_save & ~w_full;
   assign w_pop      = w_rest & ~w_empty;
   assign w_err_nxt  = w_both | (w_save & w_full) | (w_rest & w_empty);
   assign w_push_idx = r_depth[AW-1:0];
   assign w_pop_idx  = AW'(r_depth - 1'b1);

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM: next state; IDLE ignores requests during the ack cycle while requesters drop req
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (!r_ack) begin
               if (io.bus_wr_req)      w_state_nxt = BUS_WR;
               else if (io.bus_rd_req) w_state_nxt = BUS_RD;
            end
         end
         BUS_WR:  if (!w_ctx) w_state_nxt = IDLE;
         BUS_RD:  if (!w_ctx) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM: outputs; a context op this cycle defers any bus commit
   always_comb begin
      w_latch      = (r_state == IDLE) && !r_ack && io.bus_wr_req;
      w_commit_wr  = (r_state == BUS_WR) && !w_ctx;
      w_commit_rd  = (r_state == BUS_RD) && !w_ctx;
      io.alu_stall = !rst && io.alu_req && (w_ctx || (r_state == BUS_WR));
      w_alu_go     = io.alu_req && !io.alu_stall;
   end

   // Flag update priority: stack pop > bus write commit > ALU merge
   always_comb begin
      w_alu_merge = (r_flags & ~io.alu_mask) | (io.alu_flags & io.alu_mask);
      w_flags_nxt = r_flags;
      if (w_pop)            w_flags_nxt = r_stack[w_pop_idx];
      else if (w_commit_wr) w_flags_nxt = r_wlatch;
      else if (w_alu_go)    w_flags_nxt = w_alu_merge;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flags <= '0;
         r_depth <= '0;
         r_ack   <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_run   <= 1'b0;
      end else begin
         r_flags <= w_flags_nxt;
         r_ack   <= w_commit_wr | w_commit_rd;
         r_err   <= w_err_nxt;
         r_run   <= 1'b1;
         if (w_commit_rd) r_rdata <= w_flags_nxt;
         if (w_push)      r_depth <= r_depth + 1'b1;
         else if (w_pop)  r_depth <= r_depth - 1'b1;
      end
   end

   // Stack entries and the write latch are pure data, qualified by depth/state
   always_ff @(posedge clk) begin
      if (w_push)  r_stack[w_push_idx] <= r_flags;
      if (w_latch) r_wlatch <= io.bus_wdata;
   end

   assign io.sr_we     = r_run;
   assign io.sr_re     = r_run;
   assign io.sr_wdata  = r_flags;
   assign io.bus_ack   = r_ack;
   assign io.bus_rdata = r_rdata;
   assign io.ctx_err   = r_err;
   assign io.ctx_depth = r_depth;
endmodule

// File: tb/tb_sreg_ctrl.sv
// Directed bench for sreg_ctrl: table of ALU updates plus hand sequences for bus,
// context stack, collisions and reset during a bus write.
module tb_sreg_ctrl;
   localparam int W     = 3;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic [W-1:0] sr_model = '0;

   always #5 clk = ~clk;

   sreg_ctrl_if #(.W(W), .DEPTH(DEPTH)) ifc ();

   sreg_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .io  (ifc.slave)
   );

   // Status register model: keeps its value only while written
   always @(posedge clk) if (ifc.sr_we) sr_model <= ifc.sr_wdata;
   assign ifc.sr_rdata = sr_model;

   typedef struct {
      logic         req;
      logic [W-1:0] mask;
      logic [W-1:0] flg;
      logic         exp_stall;
      logic [W-1:0] exp_flags;
   } alu_vec_t;

   alu_vec_t tv [7];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_set(input logic [W-1:0] v);
      ifc.alu_req = 1'b1; ifc.alu_mask = 3'b111; ifc.alu_flags = v;
      tick();
      ifc.alu_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{1'b1, 3'b111, 3'b101, 1'b0, 3'b101};
      tv[1] = '{1'b1, 3'b011, 3'b010, 1'b0, 3'b110};
      tv[2] = '{1'b1, 3'b000, 3'b111, 1'b0, 3'b110};
      tv[3] = '{1'b0, 3'b111, 3'b000, 1'b0, 3'b110};
      tv[4] = '{1'b1, 3'b100, 3'b000, 1'b0, 3'b010};
      tv[5] = '{1'b1, 3'b101, 3'b111, 1'b0, 3'b111};
      tv[6] = '{1'b1, 3'b010, 3'b000, 1'b0, 3'b101};

      ifc.alu_req = 0; ifc.alu_mask = '0; ifc.alu_flags = '0;
      ifc.bus_wr_req = 0; ifc.bus_rd_req = 0; ifc.bus_wdata = '0;
      ifc.ctx_save = 0; ifc.ctx_restore = 0;

      // Reset state
      #12;
      chk("rst_sr_we", ifc.sr_we, 0);
      chk("rst_sr_re", ifc.sr_re, 0);
      chk("rst_sr_wdata", ifc.sr_wdata, 0);
      chk("rst_bus_ack", ifc.bus_ack, 0);
      chk("rst_bus_rdata", ifc.bus_rdata, 0);
      chk("rst_ctx_err", ifc.ctx_err, 0);
      chk("rst_alu_stall", ifc.alu_stall, 0);
      chk("rst_depth", ifc.ctx_depth, 0);
      @(negedge clk); rst = 1'b0;
      tick();
      chk("idle_sr_we", ifc.sr_we, 1);
      chk("idle_sr_re", ifc.sr_re, 1);
      chk("idle_sr_wdata", ifc.sr_wdata, 0);
      chk("idle_bus_ack", ifc.bus_ack, 0);

      // ALU update table
      for (int i = 0; i < 7; i++) begin
         ifc.alu_req = tv[i].req; ifc.alu_mask = tv[i].mask; ifc.alu_flags = tv[i].flg;
         #1;
         chk($sformatf("alu_stall[%0d]", i), ifc.alu_stall, tv[i].exp_stall);
         tick();
         chk($sformatf("alu_flags[%0d]", i), ifc.sr_wdata, tv[i].exp_flags);
      end
      ifc.alu_req = 1'b0;

      // Bus write then read
      ifc.bus_wr_req = 1'b1; ifc.bus_wdata = 3'b011;
      tick(); chk("wr_ack_c1", ifc.bus_ack, 0);
      tick(); chk("wr_ack_c2", ifc.bus_ack, 1);
      chk("wr_flags", ifc.sr_wdata, 3'b011);
      ifc.bus_wr_req = 1'b0;
      tick(); chk("wr_ack_drop", ifc.bus_ack, 0);
      ifc.bus_rd_req = 1'b1;
      tick(); chk("rd_ack_c1", ifc.bus_ack, 0);
      tick(); chk("rd_ack_c2", ifc.bus_ack, 1);
      chk("rd_data", ifc.bus_rdata, 3'b011);
      ifc.bus_rd_req = 1'b0;
      tick();

      // Simultaneous write and read: write first, read follows 3 cycles later
      ifc.bus_wr_req = 1'b1; ifc.bus_rd_req = 1'b1; ifc.bus_wdata = 3'b100;
      tick(); tick();
      chk("wrrd_wr_ack", ifc.bus_ack, 1);
      chk("wrrd_flags", ifc.sr_wdata, 3'b100);
      ifc.bus_wr_req = 1'b0;
      tick(); chk("wrrd_gap1", ifc.bus_ack, 0);
      tick(); chk("wrrd_gap2", ifc.bus_ack, 0);
      tick(); chk("wrrd_rd_ack", ifc.bus_ack, 1);
      chk("wrrd_rd_data", ifc.bus_rdata, 3'b100);
      ifc.bus_rd_req = 1'b0;
      tick();

      // Context nesting, overflow, underflow
      for (int i = 1; i <= 4; i++) begin
         alu_set(W'(i));
         ifc.ctx_save = 1'b1;
         tick();
         ifc.ctx_save = 1'b0;
         chk($sformatf("push_depth[%0d]", i), ifc.ctx_depth, i);
         chk($sformatf("push_err[%0d]", i), ifc.ctx_err, 0);
      end
      ifc.ctx_save = 1'b1;
      tick(); ifc.ctx_save = 1'b0;
      chk("ovf_err", ifc.ctx_err, 1);
      chk("ovf_depth", ifc.ctx_depth, 4);
      tick(); chk("ovf_err_drop", ifc.ctx_err, 0);
      for (int i = 4; i >= 1; i--) begin
         ifc.ctx_restore = 1'b1;
         tick(); ifc.ctx_restore = 1'b0;
         chk($sformatf("pop_flags[%0d]", i), ifc.sr_wdata, i);
         chk($sformatf("pop_depth[%0d]", i), ifc.ctx_depth, i - 1);
      end
      ifc.ctx_restore = 1'b1;
      tick(); ifc.ctx_restore = 1'b0;
      chk("unf_err", ifc.ctx_err, 1);
      chk("unf_flags", ifc.sr_wdata, 3'b001);
      chk("unf_depth", ifc.ctx_depth, 0);
      tick();

      // Save collides with ALU: pre-update value pushed, ALU applied next cycle
      ifc.ctx_save = 1'b1; ifc.alu_req = 1'b1; ifc.alu_mask = 3'b111; ifc.alu_flags = 3'b110;
      #1; chk("col_save_stall", ifc.alu_stall, 1);
      tick(); ifc.ctx_save = 1'b0;
      chk("col_save_flags", ifc.sr_wdata, 3'b001);
      chk("col_save_depth", ifc.ctx_depth, 1);
      #1; chk("col_save_unstall", ifc.alu_stall, 0);
      tick(); ifc.alu_req = 1'b0;
      chk("col_alu_applied", ifc.sr_wdata, 3'b110);
      ifc.ctx_restore = 1'b1;
      tick(); ifc.ctx_restore = 1'b0;
      chk("col_pop_pre", ifc.sr_wdata, 3'b001);

      // ALU during bus write commit
      ifc.bus_wr_req = 1'b1; ifc.bus_wdata = 3'b010;
      tick();
      ifc.alu_req = 1'b1; ifc.alu_mask = 3'b100; ifc.alu_flags = 3'b100;
      #1; chk("col_wr_stall", ifc.alu_stall, 1);
      tick(); ifc.bus_wr_req = 1'b0;
      chk("col_wr_ack", ifc.bus_ack, 1);
      chk("col_wr_flags", ifc.sr_wdata, 3'b010);
      #1; chk("col_wr_unstall", ifc.alu_stall, 0);
      tick(); ifc.alu_req = 1'b0;
      chk("col_wr_final", ifc.sr_wdata, 3'b110);

      // Read commit captures a same-cycle ALU update
      ifc.bus_rd_req = 1'b1;
      tick();
      ifc.alu_req = 1'b1; ifc.alu_mask = 3'b111; ifc.alu_flags = 3'b011;
      #1; chk("rd_alu_stall", ifc.alu_stall, 0);
      tick(); ifc.alu_req = 1'b0; ifc.bus_rd_req = 1'b0;
      chk("rd_alu_ack", ifc.bus_ack, 1);
      chk("rd_alu_data", ifc.bus_rdata, 3'b011);
      tick();

      // Save and restore together: both ignored, error flagged
      ifc.ctx_save = 1'b1;
      tick(); ifc.ctx_save = 1'b0;
      ifc.ctx_save = 1'b1; ifc.ctx_restore = 1'b1;
      tick(); ifc.ctx_save = 1'b0; ifc.ctx_restore = 1'b0;
      chk("both_err", ifc.ctx_err, 1);
      chk("both_depth", ifc.ctx_depth, 1);
      chk("both_flags", ifc.sr_wdata, 3'b011);

      // Reset in the middle of a bus write
      ifc.bus_wr_req = 1'b1; ifc.bus_wdata = 3'b111;
      tick();
      rst = 1'b1;
      #1;
      chk("mrst_flags", ifc.sr_wdata, 0);
      chk("mrst_depth", ifc.ctx_depth, 0);
      chk("mrst_sr_we", ifc.sr_we, 0);
      ifc.bus_wr_req = 1'b0;
      @(negedge clk); rst = 1'b0;
      tick();
      chk("mrst_ack1", ifc.bus_ack, 0);
      chk("mrst_flags1", ifc.sr_wdata, 0);
      chk("mrst_sr_we1", ifc.sr_we, 1);
      tick();
      chk("mrst_ack2", ifc.bus_ack, 0);
      chk("mrst_flags2", ifc.sr_wdata, 0);
      ifc.ctx_restore = 1'b1;
      tick(); ifc.ctx_restore = 1'b0;
      chk("mrst_empty_err", ifc.ctx_err, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sreg_ctrl.md
Name: sreg_ctrl

Overview:
Controller that owns the status-flag register. It arbitrates flag updates from the ALU, the I/O bus (IN/OUT to the status register) and the interrupt context logic. It holds the authoritative flag copy and drives the register's write/read enables and data every cycle. It also implements a small context stack that saves flags on interrupt entry and restores them on RETI.

Parameters:
W, 3, flag width (bit order matches the status register's flag_in/flag_out)
DEPTH, 4, context stack entries (interrupt nesting depth)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
alu_req  in  1  ALU flag update this cycle
alu_mask  in  W  flags affected by the ALU op
alu_flags  in  W  new flag values (only masked bits used)
alu_stall  out  1  ALU update not taken this cycle; ALU holds req/mask/flags
bus_wr_req  in  1  bus write request; held until bus_ack
bus_rd_req  in  1  bus read request; held until bus_ack
bus_wdata  in  W  bus write data
bus_ack  out  1  one-cycle completion strobe
bus_rdata  out  W  read data, valid while bus_ack=1
ctx_save  in  1  single-cycle pulse: push flags (interrupt entry)
ctx_restore  in  1  single-cycle pulse: pop flags (RETI)
ctx_err  out  1  one-cycle pulse: overflow or underflow
ctx_depth  out  clog2(DEPTH+1)  current stack occupancy
sr_we  out  1  status register write enable
sr_re  out  1  status register read enable
sr_wdata  out  W  status register write data
sr_rdata  in  W  status register read data (monitor only)

Behaviour:
- Reset (async, any state, aborts any transaction):
  - flags_q=0; stack empty; ctx_depth=0; state=IDLE.
  - Outputs: sr_we=0, sr_re=0, sr_wdata=0, bus_ack=0, bus_rdata=0, ctx_err=0, alu_stall=0.
- Register drive: from the first clock after reset, sr_we=1 and sr_re=1 every cycle, with sr_wdata=flags_q. This refresh write keeps the register coherent, because it does not retain its value unless written.
  - The register therefore lags flags_q by one cycle.
  - Bus reads return flags_q, never sr_rdata.
- Priority per cycle: ctx op > bus commit (BUS_WR) > ALU.
- ctx_save and ctx_restore in the same cycle: both ignored, ctx_err=1.
- ctx_save, accepted in any state:
  - Not full: push flags_q (value before any same-cycle update), depth+1.
  - Full (depth==DEPTH): no push, ctx_err=1 next cycle.
- ctx_restore, accepted in any state:
  - Not empty: flags_q <= top entry, depth-1.
  - Empty: flags_q unchanged, ctx_err=1 next cycle.
- ALU update: flags_q <= (flags_q & ~alu_mask) | (alu_flags & alu_mask) at the next edge.
  - alu_stall is combinational, =1 when alu_req and (ctx op this cycle, or state=BUS_WR committing).
  - A stalled update is applied on the first unstalled cycle.
  - alu_mask=0 is a no-op but is still a granted update.
- FSM, states IDLE, BUS_WR, BUS_RD:
  - IDLE: bus_wr_req → BUS_WR, latching bus_wdata. Else bus_rd_req → BUS_RD. A write wins over a simultaneous read.
  - BUS_WR:
    - With no ctx op: flags_q <= latched data and bus_ack=1 next cycle, → IDLE.
    - With a ctx op: commit deferred and state held.
    - Any ALU request in the commit cycle stalls.
  - BUS_RD:
    - With no ctx op: bus_rdata <= flags_q (including any same-cycle ALU update), bus_ack=1 next cycle, → IDLE.
    - With a ctx op: deferred.
  - Latency from request to ack is 2 cycles when unobstructed.
  - Requesters drop req in the ack cycle. IDLE samples requests only after that, so back-to-back bus throughput is one transaction per 3 cycles.
- Stack storage: LIFO, register array. Entries are not cleared on pop; contents are don't-care beyond ctx_depth.

Test Plan:
- Reset then idle: sr_we=0 during rst; 1 cycle after release sr_we=1, sr_re=1, sr_wdata=000; ctx_depth=0, bus_ack=0.
- Masked ALU update: flags=101, alu_req mask=011 flags=010 → flags_q=110 next edge; sr_wdata=110 the same cycle; alu_stall=0.
- Bus write then read: bus_wr_req wdata=011 → bus_ack on cycle 2, flags_q=011. Then bus_rd_req → bus_ack with bus_rdata=011. Simultaneous wr+rd → write served first.
- Context nesting: 4× ctx_save with flags 001,010,011,100 → depth=4. 5th save → ctx_err pulse, depth stays 4. 4 restores → flags 100,011,010,001. Extra restore → ctx_err, flags stay 001.
- Collisions: ctx_save with alu_req → alu_stall=1, pushed value is the pre-update flags, ALU applied next cycle. ALU request during the BUS_WR commit → stall for 1 cycle; final flags = ALU merge applied over the bus data.
- Reset mid BUS_WR: rst asserted in BUS_WR → no bus_ack, flags_q=000, state IDLE, stack empty.
